// File: rtl/counter_pkg.sv
// Shared constants and step decoding for the saturating up/down counter.
// The enum names the three things the counter can do on any clock edge.
package counter_pkg;

    localparam int DEFAULT_BW      = 7;
    localparam int DEFAULT_MAX_VAL = 99;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DOWN = 2'b10
    } step_e;

    // Coincident up and down requests cancel, so only a lone pulse moves the count.
    function automatic step_e decodeStep(input logic upPulse, input logic downPulse);
        step_e step;
        step = STEP_HOLD;
        if (upPulse && !downPulse) begin
            step = STEP_UP;
        end else if (downPulse && !upPulse) begin
            step = STEP_DOWN;
        end
        return step;
    endfunction

endpackage

// File: rtl/counter_edge_sync.sv
// Brings an asynchronous level into the clock domain through two flops.
// It then emits a one-cycle pulse for each low-to-high transition.
module edge_sync
    import counter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic r_meta;
    logic r_sync;
    logic r_delay;

    // Reset clears the whole chain, so a level that is already high at release
    // looks like a fresh rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_delay <= 1'b0;
        end else begin
            r_meta  <= sig_i;
            r_sync  <= r_meta;
            r_delay <= r_sync;
        end
    end

    assign pulse_o = r_sync & ~r_delay;

endmodule

// File: rtl/counter.sv
// Saturating up/down counter driven by two asynchronous request lines.
// The count sits directly in a register and never leaves the range 0..MAX_VAL.
module counter
    import counter_pkg::*;
#(
    parameter int BW      = DEFAULT_BW,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          up_i,
    input  logic          down_i,
    output logic [BW-1:0] counter_val_o
);

    localparam logic [BW-1:0] LP_MAX = BW'(MAX_VAL);
    localparam logic [BW-1:0] LP_ONE = BW'(1);

    logic          w_upPulse;
    logic          w_downPulse;
    step_e         w_step;
    logic [BW-1:0] r_count;

    edge_sync u_upSync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sig_i   (up_i),
        .pulse_o (w_upPulse)
    );

    edge_sync u_downSync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sig_i   (down_i),
        .pulse_o (w_downPulse)
    );

    assign w_step = decodeStep(w_upPulse, w_downPulse);

    // Up saturation clamps to LP_MAX rather than merely holding, so the count
    // cannot stay above the limit even if it were somehow disturbed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            case (w_step)
                STEP_UP: begin
                    if (r_count >= LP_MAX) begin
                        r_count <= LP_MAX;
                    end else begin
                        r_count <= r_count + LP_ONE;
                    end
                end
                STEP_DOWN: begin
                    if (r_count != '0) begin
                        r_count <= r_count - LP_ONE;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign counter_val_o = r_count;

endmodule

// File: tb/tb_counter.sv
// Checks the saturating counter against an event-level reference model.
// The model turns each sampled rising request into a +1/-1 that lands two edges later.
module tb_counter;

    localparam int MAX_COUNT = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       down;
    logic [6:0] countVal;

    int checks   = 0;
    int failures = 0;

    int   expCount  = 0;
    int   pendNext  = 0;
    int   pendLater = 0;
    logic prevUp    = 1'b0;
    logic prevDown  = 1'b0;

    counter #(.BW(7), .MAX_VAL(MAX_COUNT)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .up_i          (up),
        .down_i        (down),
        .counter_val_o (countVal)
    );

    always #5 clk = ~clk;

    // Compares the DUT count with the required value.
    task automatic checkOutput(input string tag, input int expected);
        logic [31:0] observed;
        observed = {25'd0, countVal};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock edge of the reference model: reset clears everything,
    // otherwise the net request scheduled two edges ago is applied with saturation.
    task automatic modelEdge();
        int riseUp;
        int riseDown;
        if (rst) begin
            expCount  = 0;
            pendNext  = 0;
            pendLater = 0;
            prevUp    = 1'b0;
            prevDown  = 1'b0;
        end else begin
            if (pendNext > 0 && expCount < MAX_COUNT) expCount++;
            else if (pendNext < 0 && expCount > 0) expCount--;
            riseUp    = (up && !prevUp) ? 1 : 0;
            riseDown  = (down && !prevDown) ? 1 : 0;
            pendNext  = pendLater;
            pendLater = riseUp - riseDown;
            prevUp    = up;
            prevDown  = down;
        end
    endtask

    // Drives inputs just after an edge, advances one clock and checks #1 later.
    task automatic applyStimulus(input logic r, input logic u, input logic d, input string tag);
        rst  = r;
        up   = u;
        down = d;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag, expCount);
    endtask

    // Pulses up or down until the projected count reaches target, then lets it settle.
    task automatic driveTo(input int target, input string tag);
        int guard;
        guard = 0;
        while ((expCount + pendNext + pendLater) != target && guard < 400) begin
            if ((expCount + pendNext + pendLater) < target) applyStimulus(1'b0, 1'b1, 1'b0, tag);
            else applyStimulus(1'b0, 1'b0, 1'b1, tag);
            applyStimulus(1'b0, 1'b0, 1'b0, tag);
            guard++;
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, tag);
        checkOutput(tag, target);
    endtask

    initial begin
        rst  = 1'b1;
        up   = 1'b0;
        down = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i[0], 1'b0, "resetHold");

        for (int i = 0; i < 300; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, "countUp");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "countUpSettle");
        checkOutput("saturateHigh", 99);

        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, (i % 2) == 0, "countDown");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "countDownSettle");
        checkOutput("saturateLow", 0);

        driveTo(50, "reach50");
        applyStimulus(1'b0, 1'b1, 1'b1, "simulRise");
        applyStimulus(1'b0, 1'b1, 1'b1, "simulHigh");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, "simulSettle");
        checkOutput("simulHold", 50);
        applyStimulus(1'b0, 1'b1, 1'b0, "upOnly");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, "upOnlySettle");
        checkOutput("upOnly51", 51);

        driveTo(10, "reach10");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, "heldLevel");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "heldSettle");
        checkOutput("heldOnce", 11);

        driveTo(42, "reach42");
        applyStimulus(1'b0, 1'b1, 1'b0, "midRiseSample");
        applyStimulus(1'b0, 1'b1, 1'b0, "midRiseSync");
        applyStimulus(1'b1, 1'b1, 1'b0, "midReset");
        checkOutput("midResetZero", 0);
        applyStimulus(1'b0, 1'b0, 1'b0, "afterReset");
        applyStimulus(1'b0, 1'b1, 1'b0, "nextUp");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, "nextUpSettle");
        checkOutput("nextUpOne", 1);

        driveTo(98, "reach98");
        applyStimulus(1'b0, 1'b1, 1'b0, "edgeA");
        applyStimulus(1'b0, 1'b0, 1'b0, "edgeB");
        applyStimulus(1'b0, 1'b1, 1'b0, "edgeC");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, "edgeSettle");
        checkOutput("clampAt99", 99);

        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
